// File: rtl/branch_predictor_bht.sv
// Fetch-stage branch predictor: 2-bit saturating counters plus a tagged BTB,
// trained by resolved execute-stage branches, with registered mispredict redirect and statistics.
module branch_predictor_bht #(
   parameter int unsigned IDX_BITS = 6,
   parameter int unsigned TAG_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] f_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_taken,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int unsigned ENTRIES = 1 << IDX_BITS;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [IDX_BITS-1:0] f_idx;
   logic [TAG_BITS-1:0] f_tag;
   logic [IDX_BITS-1:0] e_idx;
   logic [TAG_BITS-1:0] e_tag;
   logic                e_hit;
   logic [1:0]          ctr_next;
   logic                mispredict;

   assign f_idx = f_pc[IDX_BITS+1:2];
   assign f_tag = f_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
   assign e_idx = ex_pc[IDX_BITS+1:2];
   assign e_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

   // Lookup reads the registered arrays, so a same-cycle update is seen next cycle.
   always_comb begin
      pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      pred_taken  = pred_hit && ctr_q[f_idx][1];
      pred_target = pred_taken ? target_q[f_idx] : f_pc + 32'd4;
   end

   always_comb begin
      e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
      ctr_next = ctr_q[e_idx];
      if (ex_taken) begin
         if (ctr_q[e_idx] != 2'b11) ctr_next = ctr_q[e_idx] + 2'd1;
      end else begin
         if (ctr_q[e_idx] != 2'b00) ctr_next = ctr_q[e_idx] - 2'd1;
      end
      mispredict = ex_valid && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_pred_target != ex_target)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (ex_valid) begin
         if (e_hit) begin
            ctr_q[e_idx] <= ctr_next;
            if (ex_taken) target_q[e_idx] <= ex_target;
         end else if (ex_taken) begin
            valid_q[e_idx]  <= 1'b1;
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= ex_target;
            ctr_q[e_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush         <= 1'b0;
         redirect_pc   <= '0;
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         flush <= mispredict;
         if (ex_valid) begin
            redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
            if (br_count != '1) br_count <= br_count + 32'd1;
            if (mispredict && (mispred_count != '1)) mispred_count <= mispred_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: behavioural reference model feeding
// scoreboard queues of expected prediction and resolution results.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] f_pc;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_target, ex_pred_target;
   logic        ex_taken, ex_pred_taken;
   logic        flush;
   logic [31:0] redirect_pc, br_count, mispred_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_predictor_bht #(.IDX_BITS(6), .TAG_BITS(8)) dut (
      .clk(clk), .rst(rst), .f_pc(f_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .flush(flush), .redirect_pc(redirect_pc),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [31:0] target;
   } pred_t;

   typedef struct packed {
      logic        flush;
      logic [31:0] redirect;
      logic [31:0] br;
      logic [31:0] mis;
   } res_t;

   pred_t pred_q[$];
   res_t  res_q[$];

   // Reference model state
   logic        m_valid [64];
   logic [7:0]  m_tag   [64];
   logic [31:0] m_tgt   [64];
   logic [1:0]  m_ctr   [64];
   logic [31:0] m_br, m_mis, m_redir;

   function automatic void m_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 8'h00;
         m_tgt[i]   = 32'h0;
         m_ctr[i]   = 2'b01;
      end
      m_br = 0; m_mis = 0; m_redir = 0;
   endfunction

   function automatic pred_t m_predict(input logic [31:0] pc);
      pred_t p;
      int    i = int'(pc[7:2]);
      p.hit    = m_valid[i] && (m_tag[i] == pc[15:8]);
      p.taken  = p.hit && m_ctr[i][1];
      p.target = p.taken ? m_tgt[i] : pc + 32'd4;
      return p;
   endfunction

   function automatic res_t m_resolve(input logic [31:0] pc, input logic [31:0] tgt,
                                      input logic tk, input logic ptk, input logic [31:0] ptgt);
      res_t r;
      int   i   = int'(pc[7:2]);
      logic hit = m_valid[i] && (m_tag[i] == pc[15:8]);
      logic mp  = (tk != ptk) || (tk && (ptgt != tgt));
      if (hit) begin
         if (tk && m_ctr[i] < 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
         if (!tk && m_ctr[i] > 2'b00) m_ctr[i] = m_ctr[i] - 2'd1;
         if (tk) m_tgt[i] = tgt;
      end else if (tk) begin
         m_valid[i] = 1'b1; m_tag[i] = pc[15:8]; m_tgt[i] = tgt; m_ctr[i] = 2'b10;
      end
      m_br    = m_br + 1;
      if (mp) m_mis = m_mis + 1;
      m_redir = tk ? tgt : pc + 32'd4;
      r.flush = mp; r.redirect = m_redir; r.br = m_br; r.mis = m_mis;
      return r;
   endfunction

   task automatic check_pred(input logic [31:0] pc);
      pred_t e;
      f_pc = pc;
      pred_q.push_back(m_predict(pc));
      #1;
      e = pred_q.pop_front();
      n_vec++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.target}) begin
         n_err++;
         $display("FAIL pred pc=%h: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                  pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
      end
   endtask

   // Drives one resolved branch; the fetch lookup is checked before the edge (read-old).
   task automatic do_ex(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic ptk, input logic [31:0] ptgt);
      res_t e;
      ex_valid = 1'b1; ex_pc = pc; ex_target = tgt; ex_taken = tk;
      ex_pred_taken = ptk; ex_pred_target = ptgt;
      check_pred(f_pc);
      res_q.push_back(m_resolve(pc, tgt, tk, ptk, ptgt));
      @(posedge clk); #1;
      ex_valid = 1'b0;
      e = res_q.pop_front();
      n_vec++;
      if (flush !== e.flush) begin
         n_err++; $display("FAIL flush pc=%h: got %b want %b", pc, flush, e.flush);
      end
      n_vec++;
      if (redirect_pc !== e.redirect) begin
         n_err++; $display("FAIL redirect_pc pc=%h: got %h want %h", pc, redirect_pc, e.redirect);
      end
      n_vec++;
      if ({br_count, mispred_count} !== {e.br, e.mis}) begin
         n_err++;
         $display("FAIL counts pc=%h: got br=%0d mis=%0d want br=%0d mis=%0d",
                  pc, br_count, mispred_count, e.br, e.mis);
      end
   endtask

   task automatic idle_check();
      @(posedge clk); #1;
      n_vec++;
      if (flush !== 1'b0) begin
         n_err++; $display("FAIL idle_flush: got %b want 0", flush);
      end
   endtask

   task automatic test_reset();
      n_vec++;
      if ({flush, redirect_pc, br_count, mispred_count} !== 97'h0) begin
         n_err++;
         $display("FAIL reset_state: got flush=%b redir=%h br=%0d mis=%0d want all zero",
                  flush, redirect_pc, br_count, mispred_count);
      end
      check_pred(32'h100);
      n_vec++;
      if (pred_target !== 32'h104) begin
         n_err++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target);
      end
   endtask

   task automatic test_allocate_and_train();
      f_pc = 32'h100;
      do_ex(32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
      check_pred(32'h100);
      n_vec++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h80}) begin
         n_err++; $display("FAIL alloc_pred: got taken=%b tgt=%h want 1 00000080", pred_taken, pred_target);
      end
      for (int i = 0; i < 3; i++) do_ex(32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
      // Two not-taken mispredicts back to back: 11 -> 10 -> 01
      for (int i = 0; i < 2; i++) do_ex(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
      check_pred(32'h100);
      n_vec++;
      if ({pred_hit, pred_taken} !== 2'b10) begin
         n_err++; $display("FAIL weak_nt_pred: got hit=%b taken=%b want hit=1 taken=0", pred_hit, pred_taken);
      end
      idle_check();
   endtask

   task automatic test_target_mismatch();
      do_ex(32'h100, 32'h80, 1'b1, 1'b1, 32'h90);
      idle_check();
   endtask

   task automatic test_pc_wrap();
      f_pc = 32'hFFFF_FFFC;
      do_ex(32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 32'h40);
      n_vec++;
      if (redirect_pc !== 32'h0) begin
         n_err++; $display("FAIL wrap_redirect: got %h want 00000000", redirect_pc);
      end
      check_pred(32'hFFFF_FFFC);
   endtask

   task automatic test_back_to_back();
      do_ex(32'h208, 32'h300, 1'b1, 1'b0, 32'h20C);
      do_ex(32'h208, 32'h300, 1'b1, 1'b1, 32'h300);
      do_ex(32'h20C, 32'h400, 1'b1, 1'b0, 32'h210);
      do_ex(32'h208, 32'h300, 1'b0, 1'b1, 32'h300);
      check_pred(32'h208);
      check_pred(32'h20C);
   endtask

   task automatic test_reset_mid_update();
      do_ex(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
      ex_valid = 1'b1; ex_pc = 32'h100; ex_target = 32'h80; ex_taken = 1'b1;
      ex_pred_taken = 1'b0; ex_pred_target = 32'h104;
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({flush, br_count, mispred_count} !== 65'h0) begin
         n_err++;
         $display("FAIL async_reset: got flush=%b br=%0d mis=%0d want 0 0 0", flush, br_count, mispred_count);
      end
      m_reset();
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if ({flush, redirect_pc, br_count, mispred_count} !== 97'h0) begin
         n_err++;
         $display("FAIL post_reset: got flush=%b redir=%h br=%0d mis=%0d want all zero",
                  flush, redirect_pc, br_count, mispred_count);
      end
      check_pred(32'h100);
   endtask

   task automatic test_aliasing();
      f_pc = 32'h100;
      do_ex(32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
      check_pred(32'h100);
      do_ex(32'h4100, 32'h200, 1'b1, 1'b0, 32'h4104);
      check_pred(32'h100);
      n_vec++;
      if (pred_hit !== 1'b0) begin
         n_err++; $display("FAIL evict_0x100: got hit=%b want 0", pred_hit);
      end
      check_pred(32'h4100);
      check_pred(32'h14100);
      n_vec++;
      if ({pred_hit, pred_target} !== {1'b1, 32'h200}) begin
         n_err++; $display("FAIL silent_alias: got hit=%b tgt=%h want 1 00000200", pred_hit, pred_target);
      end
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; f_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_target = 32'h0;
      ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_allocate_and_train();
      test_target_mismatch();
      test_pc_wrap();
      test_back_to_back();
      test_reset_mid_update();
      test_aliasing();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
